// File: rtl/mux_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter_4
// Brief    : Round-robin arbiter sharing one 4:1 data mux among four
//            requesters, with locked bursts and a valid/ready output port.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter_4 #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic [3:0]       lock,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_c,
    input  logic [WIDTH-1:0] data_d,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic [3:0]       gnt,
    output logic [3:0]       ack
);

    localparam int                 c_cnt_w     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [3:0]         r_gnt;
    logic [c_cnt_w-1:0] r_beat;
    logic [1:0]         r_ptr;

    state_t             w_nxt_state;
    logic [1:0]         w_nxt_sel;
    logic [3:0]         w_nxt_gnt;
    logic [c_cnt_w-1:0] w_nxt_beat;
    logic [1:0]         w_nxt_ptr;
    logic               w_rearb;
    logic               w_xfer;
    logic               w_burst_more;
    logic [2:0]         w_pick;

    // Returns {found, index}; scans p+1 .. p+4 so the last winner ranks lowest.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    assign w_pick       = rr_pick(req, r_ptr);
    assign out_valid    = (r_state == ST_BUSY) && req[r_sel];
    assign w_xfer       = out_valid && out_ready;
    assign w_burst_more = (MAX_BURST > 1) && lock[r_sel] && (r_beat < c_last_beat);
    assign ack          = w_xfer ? r_gnt : 4'b0000;
    assign gnt          = r_gnt;
    assign sel          = r_sel;

    always_comb begin
        out_data = data_a;
        case (r_sel)
            2'd0:    out_data = data_a;
            2'd1:    out_data = data_b;
            2'd2:    out_data = data_c;
            default: out_data = data_d;
        endcase
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        w_nxt_gnt   = r_gnt;
        w_nxt_beat  = r_beat;
        w_nxt_ptr   = r_ptr;
        w_rearb     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_rearb = 1'b1;
            end
            ST_BUSY: begin
                if (w_xfer) begin
                    if (w_burst_more) begin
                        w_nxt_beat = r_beat + c_cnt_w'(1);
                    end else begin
                        w_rearb = 1'b1;
                    end
                end else if (!req[r_sel]) begin
                    // Aborted request: give the grant away without acknowledging it.
                    w_rearb = 1'b1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        if (w_rearb) begin
            w_nxt_beat = '0;
            if (w_pick[2]) begin
                w_nxt_state = ST_BUSY;
                w_nxt_sel   = w_pick[1:0];
                w_nxt_gnt   = 4'b0001 << w_pick[1:0];
                w_nxt_ptr   = w_pick[1:0];
            end else begin
                w_nxt_state = ST_IDLE;
                w_nxt_sel   = 2'd0;
                w_nxt_gnt   = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_beat  <= '0;
            r_ptr   <= 2'd3;
        end else begin
            r_state <= w_nxt_state;
            r_sel   <= w_nxt_sel;
            r_gnt   <= w_nxt_gnt;
            r_beat  <= w_nxt_beat;
            r_ptr   <= w_nxt_ptr;
        end
    end

endmodule
`default_nettype wire
